// File: rtl/counter_param_if.sv
// counter_param_if: control inputs and count/flag outputs of the parametrised counter
interface counter_param_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
);
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              dir;
  logic [1:0]        mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              clr_ovf;
  logic [WIDTH-1:0]  out;
  logic              tc;
  logic              ovf;
  logic              done;
  modport master (
    output en, load, load_val, dir, mode, step, limit, clr_ovf,
    input  out, tc, ovf, done
  );
  modport slave (
    input  en, load, load_val, dir, mode, step, limit, clr_ovf,
    output out, tc, ovf, done
  );
endinterface

// File: rtl/counter_param.sv
// counter_param: loadable up/down counter over [0, limit] with wrap, saturate and one-shot
module counter_param #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  counter_param_if.slave bus
);
  logic [WIDTH-1:0] out_d, out_q, stp, diff, bval;
  logic [WIDTH:0]   sum;
  logic             tc_d, tc_q, ovf_d, ovf_q, done_d, done_q;
  logic             over, bnd, sat, os, ev;
  always_comb begin
    stp    = WIDTH'(bus.step);
    sum    = {1'b0, out_q} + {1'b0, stp};
    diff   = out_q - stp;
    over   = out_q > bus.limit;
    bnd    = over | (bus.dir ? sum > {1'b0, bus.limit} : stp > out_q);
    os     = bus.mode == 2'b10;
    sat    = bus.mode == 2'b01 | os;
    // limit when the range shrank below out, or clamping up / wrapping down
    bval   = (over | (sat == bus.dir)) ? bus.limit : '0;
    ev     = bus.en & ~done_q;
    out_d  = bus.load ? (bus.load_val > bus.limit ? bus.limit : bus.load_val)
           : !ev ? out_q : bnd ? bval : bus.dir ? sum[WIDTH-1:0] : diff;
    tc_d   = ~bus.load & ev & bnd;
    done_d = ~bus.load & (done_q | (ev & bnd & os));
    ovf_d  = (tc_d & ~os) | (ovf_q & ~bus.clr_ovf);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end
  assign bus.out  = out_q;
  assign bus.tc   = tc_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_counter_param.sv
// tb_counter_param: directed scoreboard bench for counter_param at WIDTH=4
module tb_counter_param;
  typedef struct packed {
    logic [3:0] o;
    logic       t;
    logic       v;
    logic       d;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  counter_param_if #(.WIDTH(4), .STEP_W(4)) bus ();
  counter_param #(.WIDTH(4), .STEP_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic push(input logic [3:0] o, input logic t, input logic v, input logic d);
    exp_t e;
    e = '{o: o, t: t, v: v, d: d};
    q.push_back(e);
  endtask
  task automatic check(input string tag);
    exp_t e, obs;
    e = q.pop_front();
    obs = '{o: bus.out, t: bus.tc, v: bus.ovf, d: bus.done};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: out/tc/ovf/done got %0d/%b/%b/%b want %0d/%b/%b/%b",
             tag, obs.o, obs.t, obs.v, obs.d, e.o, e.t, e.v, e.d);
    end
  endtask
  task automatic cyc(input string tag, input logic [3:0] o, input logic t, input logic v, input logic d);
    push(o, t, v, d);
    @(posedge clk);
    #1 check(tag);
  endtask
  task automatic drive(input logic en, input logic ld, input logic [3:0] lv, input logic dr,
                       input logic [1:0] md, input logic [3:0] st, input logic [3:0] lim, input logic clr);
    bus.en = en; bus.load = ld; bus.load_val = lv; bus.dir = dr;
    bus.mode = md; bus.step = st; bus.limit = lim; bus.clr_ovf = clr;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    drive(0, 0, 0, 1, 2'b00, 1, 9, 0);
    #2 push(0, 0, 0, 0);
    check("reset");
    @(negedge clk) rst_n = 1'b1;
    // wrap up through limit 9
    drive(1, 0, 0, 1, 2'b00, 1, 9, 0);
    for (int i = 1; i <= 9; i++) cyc("wrap_count", 4'(i), 0, 0, 0);
    cyc("wrap_edge", 0, 1, 1, 0);
    cyc("wrap_after", 1, 0, 1, 0);
    // saturate down by 2 from 5
    drive(1, 1, 5, 0, 2'b01, 2, 9, 0);
    cyc("sat_load", 5, 0, 1, 0);
    bus.load = 0;
    cyc("sat_3", 3, 0, 1, 0);
    cyc("sat_1", 1, 0, 1, 0);
    cyc("sat_clamp", 0, 1, 1, 0);
    cyc("sat_retrig", 0, 1, 1, 0);
    drive(0, 0, 0, 0, 2'b01, 2, 9, 1);
    cyc("clr_ovf", 0, 0, 0, 0);
    // one-shot
    drive(1, 1, 0, 1, 2'b10, 3, 6, 0);
    cyc("os_load", 0, 0, 0, 0);
    bus.load = 0;
    cyc("os_3", 3, 0, 0, 0);
    cyc("os_6", 6, 0, 0, 0);
    cyc("os_done", 6, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc("os_frozen", 6, 0, 0, 1);
    bus.load = 1; bus.load_val = 2;
    cyc("os_reload", 2, 0, 0, 0);
    // load clamp beats a boundary, then clr_ovf loses to a wrap
    drive(1, 1, 12, 1, 2'b00, 3, 7, 0);
    cyc("load_clamp", 7, 0, 0, 0);
    drive(1, 0, 0, 1, 2'b00, 1, 7, 1);
    cyc("clr_vs_wrap", 0, 1, 1, 0);
    // limit lowered below out, with step 0 and step 1
    drive(1, 1, 8, 1, 2'b00, 0, 15, 0);
    cyc("load_8", 8, 0, 1, 0);
    drive(1, 0, 0, 1, 2'b00, 0, 4, 0);
    cyc("lower_step0", 4, 1, 1, 0);
    cyc("step0_hold", 4, 0, 1, 0);
    bus.step = 1;
    cyc("wrap_at_4", 0, 1, 1, 0);
    drive(1, 1, 8, 1, 2'b00, 1, 15, 0);
    cyc("load_8b", 8, 0, 1, 0);
    drive(1, 0, 0, 1, 2'b00, 1, 4, 0);
    cyc("lower_step1", 4, 1, 1, 0);
    // reserved mode wraps down to limit
    drive(1, 1, 0, 0, 2'b11, 1, 4, 0);
    cyc("load_0", 0, 0, 1, 0);
    bus.load = 0;
    cyc("mode3_down", 4, 1, 1, 0);
    // asynchronous reset mid-count
    drive(1, 1, 5, 1, 2'b00, 1, 9, 0);
    cyc("load_5", 5, 0, 1, 0);
    bus.load = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 push(0, 0, 0, 0);
    check("async_rst");
    @(posedge clk);
    #1 push(0, 0, 0, 0);
    check("rst_held");
    @(negedge clk) rst_n = 1'b1;
    cyc("resume", 1, 0, 0, 0);
    cyc("resume2", 2, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
